// File: rtl/dcache_nway_module.sv
`default_nettype none
// ============================================================================
// Module      : dcache_nway_module
// Description : N-way set-associative write-back data cache. Single
//               outstanding request, per-set round-robin replacement, dirty
//               victim write-back ahead of the refill read.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_nway_module #(
    parameter int WAYS   = 4,
    parameter int SETS   = 256,
    parameter int TAG_W  = 20,
    parameter int LINE_W = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_req_vld,
    output logic                             o_req_rdy,
    input  logic                             i_req_wr,
    input  logic [TAG_W-1:0]                 i_req_tag,
    input  logic [$clog2(SETS)-1:0]          i_req_idx,
    input  logic [LINE_W-1:0]                i_req_wdat,
    input  logic [LINE_W/8-1:0]              i_req_wmask,
    output logic                             o_rsp_vld,
    output logic                             o_rsp_hit,
    output logic [LINE_W-1:0]                o_rsp_rdat,
    input  logic                             i_inv,
    output logic                             o_mem_wr_vld,
    input  logic                             i_mem_wr_rdy,
    output logic [TAG_W+$clog2(SETS)-1:0]    o_mem_wr_addr,
    output logic [LINE_W-1:0]                o_mem_wr_dat,
    output logic                             o_mem_rd_vld,
    input  logic                             i_mem_rd_rdy,
    output logic [TAG_W+$clog2(SETS)-1:0]    o_mem_rd_addr,
    input  logic                             i_mem_rsp_vld,
    input  logic [LINE_W-1:0]                i_mem_rsp_dat
);

    localparam int IDX_W = $clog2(SETS);
    localparam int MSK_W = LINE_W / 8;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WB      = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Per-set state: valid/dirty bits per way and the round-robin pointer
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  ptr_q   [SETS];
    // Tag and data storage; contents are meaningless while the valid bit is clear
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] line_q  [SETS][WAYS];

    // Registered request and chosen victim
    logic              req_wr_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [LINE_W-1:0] req_wdat_q;
    logic [MSK_W-1:0]  req_wmask_q;
    logic [WAY_W-1:0]  vic_q;

    logic              accept;
    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  vic_sel;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] fill_line;

    // Byte-wise merge of store data into a line
    function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] base,
                                                     input logic [LINE_W-1:0] wdat,
                                                     input logic [MSK_W-1:0]  mask);
        logic [LINE_W-1:0] res;
        res = base;
        for (int b = 0; b < MSK_W; b++) begin
            if (mask[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

    assign o_req_rdy = rst_n && (state_q == S_IDLE) && !i_inv;
    assign accept    = o_req_rdy && i_req_vld;

    // Tag compare and victim choice; descending scan so the lowest index wins
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        vic_sel = ptr_q[req_idx_q];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
            if (!valid_q[req_idx_q][w]) vic_sel = WAY_W'(w);
        end
    end

    assign hit       = |hit_vec;
    assign hit_line  = req_wr_q ? merge_line(line_q[req_idx_q][hit_way], req_wdat_q, req_wmask_q)
                                : line_q[req_idx_q][hit_way];
    assign fill_line = req_wr_q ? merge_line(i_mem_rsp_dat, req_wdat_q, req_wmask_q)
                                : i_mem_rsp_dat;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        o_rsp_vld     = 1'b0;
        o_rsp_hit     = 1'b0;
        o_rsp_rdat    = '0;
        o_mem_wr_vld  = 1'b0;
        o_mem_wr_addr = '0;
        o_mem_wr_dat  = '0;
        o_mem_rd_vld  = 1'b0;
        o_mem_rd_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    o_rsp_vld  = 1'b1;
                    o_rsp_hit  = 1'b1;
                    o_rsp_rdat = hit_line;
                    state_d    = S_IDLE;
                end else if (valid_q[req_idx_q][vic_sel] && dirty_q[req_idx_q][vic_sel]) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_WB: begin
                o_mem_wr_vld  = 1'b1;
                o_mem_wr_addr = {tag_q[req_idx_q][vic_q], req_idx_q};
                o_mem_wr_dat  = line_q[req_idx_q][vic_q];
                if (i_mem_wr_rdy) state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                o_mem_rd_vld  = 1'b1;
                o_mem_rd_addr = {req_tag_q, req_idx_q};
                if (i_mem_rd_rdy) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_mem_rsp_vld) begin
                    o_rsp_vld  = 1'b1;
                    o_rsp_rdat = fill_line;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture request fields on accept and the victim way at lookup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_q    <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_wdat_q  <= '0;
            req_wmask_q <= '0;
            vic_q       <= '0;
        end else begin
            if (accept) begin
                req_wr_q    <= i_req_wr;
                req_tag_q   <= i_req_tag;
                req_idx_q   <= i_req_idx;
                req_wdat_q  <= i_req_wdat;
                req_wmask_q <= i_req_wmask;
            end
            if (state_q == S_LOOKUP) vic_q <= vic_sel;
        end
    end

    // Valid, dirty and replacement-pointer maintenance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (state_q == S_IDLE && i_inv) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (state_q == S_LOOKUP && hit && req_wr_q) begin
            dirty_q[req_idx_q][hit_way] <= 1'b1;
        end else if (state_q == S_RD_WAIT && i_mem_rsp_vld) begin
            valid_q[req_idx_q][vic_q] <= 1'b1;
            dirty_q[req_idx_q][vic_q] <= req_wr_q;
            // Only replacing a live line moves the pointer on
            if (valid_q[req_idx_q][vic_q]) ptr_q[req_idx_q] <= ptr_q[req_idx_q] + 1'b1;
        end
    end

    // Tag and line array writes: store-hit merge and refill install
    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && hit && req_wr_q) begin
            line_q[req_idx_q][hit_way] <= hit_line;
        end
        if (state_q == S_RD_WAIT && i_mem_rsp_vld) begin
            tag_q[req_idx_q][vic_q]  <= req_tag_q;
            line_q[req_idx_q][vic_q] <= fill_line;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_nway_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_nway_module
// Description : Directed self-checking bench for dcache_nway_module
//               (WAYS=4, SETS=16, TAG_W=8, LINE_W=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_nway_module;

    localparam int WAYS   = 4;
    localparam int SETS   = 16;
    localparam int TAG_W  = 8;
    localparam int LINE_W = 64;

    logic        clk;
    logic        rst_n;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic        i_req_wr;
    logic [7:0]  i_req_tag;
    logic [3:0]  i_req_idx;
    logic [63:0] i_req_wdat;
    logic [7:0]  i_req_wmask;
    logic        o_rsp_vld;
    logic        o_rsp_hit;
    logic [63:0] o_rsp_rdat;
    logic        i_inv;
    logic        o_mem_wr_vld;
    logic        i_mem_wr_rdy;
    logic [11:0] o_mem_wr_addr;
    logic [63:0] o_mem_wr_dat;
    logic        o_mem_rd_vld;
    logic        i_mem_rd_rdy;
    logic [11:0] o_mem_rd_addr;
    logic        i_mem_rsp_vld;
    logic [63:0] i_mem_rsp_dat;

    int n_cmp = 0;
    int n_bad = 0;

    dcache_nway_module #(
        .WAYS   (WAYS),
        .SETS   (SETS),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_vld     (i_req_vld),
        .o_req_rdy     (o_req_rdy),
        .i_req_wr      (i_req_wr),
        .i_req_tag     (i_req_tag),
        .i_req_idx     (i_req_idx),
        .i_req_wdat    (i_req_wdat),
        .i_req_wmask   (i_req_wmask),
        .o_rsp_vld     (o_rsp_vld),
        .o_rsp_hit     (o_rsp_hit),
        .o_rsp_rdat    (o_rsp_rdat),
        .i_inv         (i_inv),
        .o_mem_wr_vld  (o_mem_wr_vld),
        .i_mem_wr_rdy  (i_mem_wr_rdy),
        .o_mem_wr_addr (o_mem_wr_addr),
        .o_mem_wr_dat  (o_mem_wr_dat),
        .o_mem_rd_vld  (o_mem_rd_vld),
        .i_mem_rd_rdy  (i_mem_rd_rdy),
        .o_mem_rd_addr (o_mem_rd_addr),
        .i_mem_rsp_vld (i_mem_rsp_vld),
        .i_mem_rsp_dat (i_mem_rsp_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // On every response, at most one valid way of the addressed set may match
    always @(negedge clk) begin
        if (rst_n && o_rsp_vld) begin
            int nm;
            nm = 0;
            for (int w = 0; w < WAYS; w++) begin
                if (dut.valid_q[dut.req_idx_q][w] && dut.tag_q[dut.req_idx_q][w] == dut.req_tag_q) nm++;
            end
            chk("single_way_match", 64'(nm <= 1), 64'd1);
        end
    end

    // One complete request; called and returns 1 time unit after a rising edge
    task automatic do_req(input logic wr, input logic [7:0] tag, input logic [3:0] idx,
                          input logic [63:0] wdat, input logic [7:0] wmask,
                          input logic exp_hit, input logic [63:0] rsp_line,
                          input logic [63:0] exp_rdat, input logic exp_wb,
                          input logic [11:0] exp_wb_addr, input logic [63:0] exp_wb_dat,
                          input int stall);
        logic saw_wb;
        logic ok;
        int   n;
        saw_wb      = 1'b0;
        i_req_vld   = 1'b1;
        i_req_wr    = wr;
        i_req_tag   = tag;
        i_req_idx   = idx;
        i_req_wdat  = wdat;
        i_req_wmask = wmask;
        #1;
        chk("req_rdy", 64'(o_req_rdy), 64'd1);
        @(posedge clk); #1;
        i_req_vld   = 1'b0;
        i_req_wdat  = '1;
        i_req_wmask = '1;
        i_req_tag   = ~tag;
        #1;
        chk("lookup_rsp_vld", 64'(o_rsp_vld), 64'(exp_hit));
        if (exp_hit) begin
            chk("lookup_hit", 64'(o_rsp_hit), 64'd1);
            chk("hit_rdat", o_rsp_rdat, exp_rdat);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            n = 0;
            while (!o_mem_rd_vld && n < 40) begin
                if (o_mem_wr_vld) begin
                    chk("wb_addr", 64'(o_mem_wr_addr), 64'(exp_wb_addr));
                    chk("wb_dat", o_mem_wr_dat, exp_wb_dat);
                    saw_wb = 1'b1;
                    ok     = 1'b1;
                    for (int k = 0; k < stall; k++) begin
                        @(posedge clk); #1;
                        if (!(o_mem_wr_vld && o_mem_wr_addr == exp_wb_addr &&
                              o_mem_wr_dat == exp_wb_dat && !o_req_rdy && !o_mem_rd_vld)) ok = 1'b0;
                    end
                    if (stall > 0) chk("wb_stall_stable", 64'(ok), 64'd1);
                    i_mem_wr_rdy = 1'b1;
                    @(posedge clk); #1;
                    i_mem_wr_rdy = 1'b0;
                end else begin
                    @(posedge clk); #1;
                end
                n++;
            end
            chk("wb_seen", 64'(saw_wb), 64'(exp_wb));
            chk("rd_vld", 64'(o_mem_rd_vld), 64'd1);
            chk("rd_addr", 64'(o_mem_rd_addr), 64'({tag, idx}));
            ok = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                if (!(o_mem_rd_vld && o_mem_rd_addr == {tag, idx} && !o_req_rdy && !o_mem_wr_vld)) ok = 1'b0;
            end
            if (stall > 0) chk("rd_stall_stable", 64'(ok), 64'd1);
            i_mem_rd_rdy = 1'b1;
            @(posedge clk); #1;
            i_mem_rd_rdy = 1'b0;
            #1;
            chk("wait_no_rsp", 64'(o_rsp_vld), 64'd0);
            i_mem_rsp_vld = 1'b1;
            i_mem_rsp_dat = rsp_line;
            #1;
            chk("miss_rsp_vld", 64'(o_rsp_vld), 64'd1);
            chk("miss_rsp_hit", 64'(o_rsp_hit), 64'd0);
            chk("miss_rdat", o_rsp_rdat, exp_rdat);
            @(posedge clk); #1;
            i_mem_rsp_vld = 1'b0;
            i_mem_rsp_dat = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n         = 1'b0;
        i_req_vld     = 1'b0;
        i_req_wr      = 1'b0;
        i_req_tag     = '0;
        i_req_idx     = '0;
        i_req_wdat    = '0;
        i_req_wmask   = '0;
        i_inv         = 1'b0;
        i_mem_wr_rdy  = 1'b0;
        i_mem_rd_rdy  = 1'b0;
        i_mem_rsp_vld = 1'b0;
        i_mem_rsp_dat = '0;
        #2;
        // Reset state
        chk("rst_req_rdy", 64'(o_req_rdy), 64'd0);
        chk("rst_rsp_vld", 64'(o_rsp_vld), 64'd0);
        chk("rst_wr_vld", 64'(o_mem_wr_vld), 64'd0);
        chk("rst_rd_vld", 64'(o_mem_rd_vld), 64'd0);
        chk("rst_rdat", o_rsp_rdat, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(o_req_rdy), 64'd1);
        @(posedge clk); #1;

        // Cold load miss, then hit with one-cycle latency
        do_req(1'b0, 8'h12, 4'd3, 64'd0, 8'h00, 1'b0, 64'hA5A5, 64'hA5A5, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h12, 4'd3, 64'd0, 8'h00, 1'b1, 64'd0, 64'hA5A5, 1'b0, 12'h0, 64'd0, 0);
        // Store hit: low byte replaced, line becomes dirty
        do_req(1'b1, 8'h12, 4'd3, 64'hFF, 8'h01, 1'b1, 64'd0, 64'hA5FF, 1'b0, 12'h0, 64'd0, 0);
        chk("dirty_after_store", 64'(dut.dirty_q[3][0]), 64'd1);

        // Fill idx 5 with four tags, then replace round-robin
        for (int t = 0; t < 4; t++) begin
            do_req(1'b0, 8'h40 + 8'(t), 4'd5, 64'd0, 8'h00, 1'b0, 64'h500 + 64'(t),
                   64'h500 + 64'(t), 1'b0, 12'h0, 64'd0, 0);
        end
        chk("ptr5_after_fill", 64'(dut.ptr_q[5]), 64'd0);
        do_req(1'b0, 8'h44, 4'd5, 64'd0, 8'h00, 1'b0, 64'h544, 64'h544, 1'b0, 12'h0, 64'd0, 0);
        chk("ptr5_after_replace", 64'(dut.ptr_q[5]), 64'd1);
        do_req(1'b0, 8'h41, 4'd5, 64'd0, 8'h00, 1'b1, 64'd0, 64'h501, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h40, 4'd5, 64'd0, 8'h00, 1'b0, 64'h540, 64'h540, 1'b0, 12'h0, 64'd0, 0);
        chk("ptr5_second_replace", 64'(dut.ptr_q[5]), 64'd2);

        // Fill the rest of idx 3, then evict the dirty line with stalled memory
        do_req(1'b0, 8'h20, 4'd3, 64'd0, 8'h00, 1'b0, 64'h2020, 64'h2020, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h21, 4'd3, 64'd0, 8'h00, 1'b0, 64'h2121, 64'h2121, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h22, 4'd3, 64'd0, 8'h00, 1'b0, 64'h2222, 64'h2222, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h23, 4'd3, 64'd0, 8'h00, 1'b0, 64'h2323, 64'h2323, 1'b1, 12'h123, 64'hA5FF, 10);

        // Store miss merges into the refill line
        do_req(1'b1, 8'h30, 4'd7, 64'h1122334455667788, 8'hF0, 1'b0, 64'hAAAAAAAAAAAAAAAA,
               64'h11223344AAAAAAAA, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h30, 4'd7, 64'd0, 8'h00, 1'b1, 64'd0, 64'h11223344AAAAAAAA, 1'b0, 12'h0, 64'd0, 0);

        // Invalidate-all takes priority over a request and drops dirty lines
        i_inv     = 1'b1;
        i_req_vld = 1'b1;
        i_req_tag = 8'h30;
        i_req_idx = 4'd7;
        #1;
        chk("inv_rdy_low", 64'(o_req_rdy), 64'd0);
        @(posedge clk); #1;
        i_inv     = 1'b0;
        i_req_vld = 1'b0;
        #1;
        chk("inv_stays_idle", 64'(o_req_rdy), 64'd1);
        do_req(1'b0, 8'h30, 4'd7, 64'd0, 8'h00, 1'b0, 64'h77, 64'h77, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h12, 4'd3, 64'd0, 8'h00, 1'b0, 64'h1212, 64'h1212, 1'b0, 12'h0, 64'd0, 0);

        // Reset while waiting for refill data
        i_req_vld = 1'b1;
        i_req_wr  = 1'b0;
        i_req_tag = 8'h55;
        i_req_idx = 4'd9;
        @(posedge clk); #1;
        i_req_vld = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_rd_vld", 64'(o_mem_rd_vld), 64'd1);
        i_mem_rd_rdy = 1'b1;
        @(posedge clk); #1;
        i_mem_rd_rdy  = 1'b0;
        i_mem_rsp_vld = 1'b1;
        i_mem_rsp_dat = 64'hDEAD;
        rst_n         = 1'b0;
        #1;
        chk("midrst_rsp_vld", 64'(o_rsp_vld), 64'd0);
        chk("midrst_rdy", 64'(o_req_rdy), 64'd0);
        chk("midrst_rd_vld", 64'(o_mem_rd_vld), 64'd0);
        chk("midrst_rdat", o_rsp_rdat, 64'd0);
        chk("midrst_rd_addr", 64'(o_mem_rd_addr), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("late_rsp_ignored", 64'(o_rsp_vld), 64'd0);
        @(posedge clk); #1;
        chk("late_rsp_ignored2", 64'(o_rsp_vld), 64'd0);
        i_mem_rsp_vld = 1'b0;
        i_mem_rsp_dat = '0;
        do_req(1'b0, 8'h55, 4'd9, 64'd0, 8'h00, 1'b0, 64'h5555, 64'h5555, 1'b0, 12'h0, 64'd0, 0);
        do_req(1'b0, 8'h23, 4'd3, 64'd0, 8'h00, 1'b0, 64'h3333, 64'h3333, 1'b0, 12'h0, 64'd0, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
